// File: rtl/layer_input_sequencer.sv
// layer_input_sequencer
// Gathers one full layer of activation values (one lane per neuron) from the
// aggregator and replays it as a stream of (index, value) beats. Once every
// lane has been seen, the stream runs for NUM_NEURON accepted beats, and then
// the block goes back to collecting. The aggregator therefore never has to
// hold its values while the neuron array is busy.
module layer_input_sequencer #(
    parameter int NUM_NEURON = 6,
    parameter int VALUE_SIZE = 9,
    parameter int INDEX_SIZE = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_NEURON*VALUE_SIZE-1:0] in_values,
    input  logic [NUM_NEURON-1:0]            in_valid,
    output logic                             in_ready,
    output logic [VALUE_SIZE-1:0]            out_value,
    output logic [INDEX_SIZE-1:0]            out_index,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             out_last,
    output logic                             layer_done
);

    localparam logic [0:0] ST_COLLECT = 1'b0;
    localparam logic [0:0] ST_STREAM  = 1'b1;

    localparam logic [INDEX_SIZE-1:0] IDX_LAST = INDEX_SIZE'(NUM_NEURON - 1);
    localparam logic [INDEX_SIZE-1:0] IDX_ZERO = {INDEX_SIZE{1'b0}};
    localparam logic [INDEX_SIZE-1:0] IDX_ONE  = INDEX_SIZE'(1);

    logic [0:0]            state_r;
    logic [0:0]            state_nxt_s;
    logic [NUM_NEURON-1:0] captured_r;
    logic [NUM_NEURON-1:0] captured_nxt_s;
    logic [INDEX_SIZE-1:0] idx_r;
    logic [INDEX_SIZE-1:0] idx_nxt_s;
    logic [VALUE_SIZE-1:0] buffer_r     [NUM_NEURON];
    logic [VALUE_SIZE-1:0] buffer_nxt_s [NUM_NEURON];
    logic                  done_nxt_s;

    logic                  in_ready_r;
    logic                  out_valid_r;
    logic                  out_last_r;
    logic                  layer_done_r;
    logic [VALUE_SIZE-1:0] out_value_r;

    // Next-state logic: lane capture while collecting, index advance while streaming.
    always_comb begin
        state_nxt_s    = state_r;
        captured_nxt_s = captured_r;
        idx_nxt_s      = idx_r;
        buffer_nxt_s   = buffer_r;
        done_nxt_s     = 1'b0;
        case (state_r)
            ST_COLLECT: begin
                for (int i = 0; i < NUM_NEURON; i++) begin
                    if (in_valid[i]) begin
                        buffer_nxt_s[i]   = in_values[i*VALUE_SIZE +: VALUE_SIZE];
                        captured_nxt_s[i] = 1'b1;
                    end else begin
                        buffer_nxt_s[i]   = buffer_r[i];
                        captured_nxt_s[i] = captured_r[i];
                    end
                end
                if (&captured_nxt_s) begin
                    state_nxt_s = ST_STREAM;
                    idx_nxt_s   = IDX_ZERO;
                end else begin
                    state_nxt_s = ST_COLLECT;
                    idx_nxt_s   = idx_r;
                end
            end
            ST_STREAM: begin
                // out_valid is implied by being in this state
                if (out_ready) begin
                    if (idx_r == IDX_LAST) begin
                        idx_nxt_s      = IDX_ZERO;
                        captured_nxt_s = {NUM_NEURON{1'b0}};
                        state_nxt_s    = ST_COLLECT;
                        done_nxt_s     = 1'b1;
                    end else begin
                        idx_nxt_s      = idx_r + IDX_ONE;
                    end
                end else begin
                    idx_nxt_s = idx_r;
                end
            end
            default: begin
                state_nxt_s    = ST_COLLECT;
                captured_nxt_s = {NUM_NEURON{1'b0}};
                idx_nxt_s      = IDX_ZERO;
            end
        endcase
    end

    // State, buffer and registered output updates; rst discards everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_COLLECT;
            captured_r   <= {NUM_NEURON{1'b0}};
            idx_r        <= IDX_ZERO;
            for (int i = 0; i < NUM_NEURON; i++) begin
                buffer_r[i] <= {VALUE_SIZE{1'b0}};
            end
            in_ready_r   <= 1'b1;
            out_valid_r  <= 1'b0;
            out_last_r   <= 1'b0;
            layer_done_r <= 1'b0;
            out_value_r  <= {VALUE_SIZE{1'b0}};
        end else begin
            state_r      <= state_nxt_s;
            captured_r   <= captured_nxt_s;
            idx_r        <= idx_nxt_s;
            buffer_r     <= buffer_nxt_s;
            in_ready_r   <= (state_nxt_s == ST_COLLECT);
            out_valid_r  <= (state_nxt_s == ST_STREAM);
            out_last_r   <= (state_nxt_s == ST_STREAM) && (idx_nxt_s == IDX_LAST);
            layer_done_r <= done_nxt_s;
            // Pre-select the lane that will be presented next cycle so the
            // output value comes straight from a flop.
            out_value_r  <= buffer_nxt_s[idx_nxt_s];
        end
    end

    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;
    assign out_last   = out_last_r;
    assign layer_done = layer_done_r;
    assign out_value  = out_value_r;
    assign out_index  = idx_r;

endmodule
